// File: rtl/lcplc_sample_framer.sv
// lcplc_sample_framer: frames a flat raw-sample stream for the LCPLC coder core
//
// Samples arrive in coder order (slice, then band, then row-major within the
// band). Four nested counters derive the row/slice/band/image boundary flags,
// and each sample plus its flags is presented through a one-entry output
// register on the coder's x_* handshake.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   cfg_*_m1          geometry (cols, rows, bands, slices), each minus 1;
//                     latched at the first sample of an image
//   input_valid/ready raw sample handshake; input_data is the sample
//   input_last        upstream end-of-image marker (checked only when enabled)
//   x_valid/x_ready   framed sample handshake toward the coder
//   x_data            framed sample
//   x_last_r/s/b/i    row / slice-in-band / last-band / image boundary flags
//   busy              high while an image is in progress
//   err_last          sticky input_last mismatch
//
// Build option: define LCPLC_FRAMER_LAST_CHECK_EN to compare input_last with
// the computed image flag; otherwise input_last is ignored and err_last is 0.
module lcplc_sample_framer #(
    parameter int DATA_WIDTH  = 16,
    parameter int COL_WIDTH   = 8,
    parameter int ROW_WIDTH   = 8,
    parameter int BAND_WIDTH  = 10,
    parameter int SLICE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COL_WIDTH-1:0]   cfg_cols_m1,
    input  logic [ROW_WIDTH-1:0]   cfg_rows_m1,
    input  logic [BAND_WIDTH-1:0]  cfg_bands_m1,
    input  logic [SLICE_WIDTH-1:0] cfg_slices_m1,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [DATA_WIDTH-1:0]  input_data,
    input  logic                   input_last,
    output logic                   x_valid,
    input  logic                   x_ready,
    output logic [DATA_WIDTH-1:0]  x_data,
    output logic                   x_last_r,
    output logic                   x_last_s,
    output logic                   x_last_b,
    output logic                   x_last_i,
    output logic                   busy,
    output logic                   err_last
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic [COL_WIDTH-1:0]   col_q, col_d, cols_q, cols_m1;
    logic [ROW_WIDTH-1:0]   row_q, row_d, rows_q, rows_m1;
    logic [BAND_WIDTH-1:0]  band_q, band_d, bands_q, bands_m1;
    logic [SLICE_WIDTH-1:0] slice_q, slice_d, slices_q, slices_m1;
    logic                   x_valid_q;
    logic [DATA_WIDTH-1:0]  x_data_q;
    logic [3:0]             flags_q;
    logic                   hs, f_r, f_s, f_b, f_i;

    assign input_ready = !x_valid_q || x_ready;
    assign hs          = input_valid && input_ready;

    // The first beat of an image sees the live config; afterwards the shadow
    // copy keeps the geometry fixed until the image completes.
    assign cols_m1   = (state_q == IDLE) ? cfg_cols_m1   : cols_q;
    assign rows_m1   = (state_q == IDLE) ? cfg_rows_m1   : rows_q;
    assign bands_m1  = (state_q == IDLE) ? cfg_bands_m1  : bands_q;
    assign slices_m1 = (state_q == IDLE) ? cfg_slices_m1 : slices_q;

    assign f_r = col_q == cols_m1;
    assign f_s = f_r && (row_q == rows_m1);
    assign f_b = f_s && (band_q == bands_m1);
    assign f_i = f_b && (slice_q == slices_m1);

    always_comb begin
        col_d   = f_r ? '0 : col_q + 1'b1;
        row_d   = f_s ? '0 : (f_r ? row_q + 1'b1 : row_q);
        band_d  = f_b ? '0 : (f_s ? band_q + 1'b1 : band_q);
        slice_d = f_i ? '0 : (f_b ? slice_q + 1'b1 : slice_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            band_q    <= '0;
            slice_q   <= '0;
            cols_q    <= '0;
            rows_q    <= '0;
            bands_q   <= '0;
            slices_q  <= '0;
            x_valid_q <= 1'b0;
            x_data_q  <= '0;
            flags_q   <= '0;
        end else if (hs) begin
            if (state_q == IDLE) begin
                cols_q   <= cfg_cols_m1;
                rows_q   <= cfg_rows_m1;
                bands_q  <= cfg_bands_m1;
                slices_q <= cfg_slices_m1;
            end
            // The image-closing beat (including a single-sample image) lands in IDLE.
            state_q   <= f_i ? IDLE : RUN;
            busy_q    <= !f_i;
            col_q     <= col_d;
            row_q     <= row_d;
            band_q    <= band_d;
            slice_q   <= slice_d;
            x_valid_q <= 1'b1;
            x_data_q  <= input_data;
            flags_q   <= {f_i, f_b, f_s, f_r};
        end else if (x_ready) begin
            x_valid_q <= 1'b0;
        end
    end

    assign x_valid  = x_valid_q;
    assign x_data   = x_data_q;
    assign x_last_r = flags_q[0];
    assign x_last_s = flags_q[1];
    assign x_last_b = flags_q[2];
    assign x_last_i = flags_q[3];
    assign busy     = busy_q;

`ifdef LCPLC_FRAMER_LAST_CHECK_EN
    logic err_q;

    // Framing always follows the counters; input_last only raises the alarm.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (hs && (input_last != f_i)) begin
            err_q <= 1'b1;
        end
    end

    assign err_last = err_q;
`else
    logic unused_last;

    assign unused_last = input_last;
    assign err_last    = 1'b0;
`endif
endmodule

// File: tb/tb_lcplc_sample_framer.sv
// tb_lcplc_sample_framer: directed self-checking bench for lcplc_sample_framer
module tb_lcplc_sample_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cfg_cols_m1 = '0;
    logic [7:0]  cfg_rows_m1 = '0;
    logic [9:0]  cfg_bands_m1 = '0;
    logic [15:0] cfg_slices_m1 = '0;
    logic        input_valid = 1'b0;
    logic        input_ready;
    logic [15:0] input_data = '0;
    logic        input_last = 1'b0;
    logic        x_valid;
    logic        x_ready = 1'b0;
    logic [15:0] x_data;
    logic        x_last_r, x_last_s, x_last_b, x_last_i;
    logic        busy;
    logic        err_last;

    int  chk_cnt  = 0;
    int  pass_cnt = 0;
    bit  exp_err  = 1'b0;

    lcplc_sample_framer dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_cols_m1  (cfg_cols_m1),
        .cfg_rows_m1  (cfg_rows_m1),
        .cfg_bands_m1 (cfg_bands_m1),
        .cfg_slices_m1(cfg_slices_m1),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .input_last   (input_last),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_data       (x_data),
        .x_last_r     (x_last_r),
        .x_last_s     (x_last_s),
        .x_last_b     (x_last_b),
        .x_last_i     (x_last_i),
        .busy         (busy),
        .err_last     (err_last)
    );

    always #5 clk = ~clk;

    // Expected {i,b,s,r} for image-relative sample index idx with counts c,r,b,s.
    function automatic logic [3:0] model(input int idx, input int c, input int r, input int b, input int s);
        logic fr, fs, fb, fi;
        fr = (idx % c) == c - 1;
        fs = fr && ((idx / c) % r) == r - 1;
        fb = fs && ((idx / (c * r)) % b) == b - 1;
        fi = fb && ((idx / (c * r * b)) % s) == s - 1;
        return {fi, fb, fs, fr};
    endfunction

    // Streams n samples (dbase+k), optionally stalling x_ready 1,0,0,1; checks
    // every cycle against an output-register / busy / err model.
    task automatic run_stream(input int n, input int cm1, input int rm1, input int bm1, input int sm1,
                              input logic [15:0] dbase, input bit stall, input int chg_at,
                              input int chg_val, input int last_at, output int cycles);
        int         sent = 0;
        int         got = 0;
        int         cyc = 0;
        bit         exp_valid = 1'b0;
        bit         exp_busy = 1'b0;
        bit         exp_ready;
        bit         stalled = 1'b0;
        logic [19:0] held = '0;
        logic [19:0] obs;
        logic [19:0] exp_o;
        logic [3:0]  f;
        while (got < n && cyc < 1000) begin
            x_ready     = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            input_valid = sent < n;
            input_data  = dbase + 16'(sent);
            input_last  = (last_at < 0) ? (sent == n - 1) : (sent == last_at);
            if (sent == chg_at) cfg_cols_m1 = 8'(chg_val);
            #1;
            obs = {x_data, x_last_i, x_last_b, x_last_s, x_last_r};
            exp_ready = !exp_valid || x_ready;
            chk_cnt++;
            if (x_valid !== exp_valid) $display("FAIL x_valid cyc=%0d got=%b exp=%b", cyc, x_valid, exp_valid);
            else pass_cnt++;
            chk_cnt++;
            if (input_ready !== exp_ready) $display("FAIL input_ready cyc=%0d got=%b exp=%b", cyc, input_ready, exp_ready);
            else pass_cnt++;
            chk_cnt++;
            if (busy !== exp_busy || err_last !== exp_err)
                $display("FAIL busy_err cyc=%0d got=%b%b exp=%b%b", cyc, busy, err_last, exp_busy, exp_err);
            else pass_cnt++;
            if (stalled) begin
                chk_cnt++;
                if (obs !== held) $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, obs, held);
                else pass_cnt++;
            end
            stalled = exp_valid && !x_ready;
            held = obs;
            if (exp_valid && x_ready) begin
                exp_o = {dbase + 16'(got), model(got, cm1 + 1, rm1 + 1, bm1 + 1, sm1 + 1)};
                chk_cnt++;
                if (obs !== exp_o) $display("FAIL beat%0d data_flags got=%h exp=%h", got, obs, exp_o);
                else pass_cnt++;
                got++;
            end
            if (input_valid && exp_ready) begin
                f = model(sent, cm1 + 1, rm1 + 1, bm1 + 1, sm1 + 1);
                exp_valid = 1'b1;
                exp_busy  = !f[3];
`ifdef LCPLC_FRAMER_LAST_CHECK_EN
                if (input_last != f[3]) exp_err = 1'b1;
`endif
                sent++;
            end else if (exp_valid && x_ready) begin
                exp_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        input_valid = 1'b0;
        input_last  = 1'b0;
        cycles = cyc;
        chk_cnt++;
        if (got != n) $display("FAIL stream_timeout got=%0d exp=%0d", got, n);
        else pass_cnt++;
    endtask

    task automatic set_cfg(input int c, input int r, input int b, input int s);
        cfg_cols_m1   = 8'(c);
        cfg_rows_m1   = 8'(r);
        cfg_bands_m1  = 10'(b);
        cfg_slices_m1 = 16'(s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cnt++;
        if ({x_valid, x_data, x_last_i, x_last_b, x_last_s, x_last_r, busy, err_last, input_ready} !== 24'h000001)
            $display("FAIL reset_state got=%h exp=%h",
                     {x_valid, x_data, x_last_i, x_last_b, x_last_s, x_last_r, busy, err_last, input_ready}, 24'h000001);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        int cyc;
        set_cfg(3, 1, 2, 1);
        run_stream(48, 3, 1, 2, 1, 16'h0000, 1'b0, -1, 0, -1, cyc);
        chk_cnt++;
        if (cyc != 49) $display("FAIL throughput cycles got=%0d exp=49", cyc);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int cyc;
        set_cfg(0, 0, 0, 0);
        run_stream(1, 0, 0, 0, 0, 16'hABCD, 1'b0, -1, 0, -1, cyc);
        run_stream(1, 0, 0, 0, 0, 16'hABCD, 1'b0, -1, 0, -1, cyc);
    endtask

    task automatic test_back_to_back_stall();
        int cyc;
        set_cfg(3, 1, 2, 1);
        run_stream(48, 3, 1, 2, 1, 16'h1000, 1'b1, -1, 0, -1, cyc);
    endtask

    task automatic test_cfg_change();
        int cyc;
        set_cfg(3, 1, 2, 1);
        run_stream(48, 3, 1, 2, 1, 16'h2000, 1'b0, 6, 1, -1, cyc);
        run_stream(24, 1, 1, 2, 1, 16'h3000, 1'b0, -1, 0, -1, cyc);
    endtask

    task automatic test_mid_reset();
        int cyc;
        set_cfg(3, 1, 2, 1);
        x_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            input_valid = 1'b1;
            input_data  = 16'h4000 + 16'(k);
            input_last  = 1'b0;
            @(posedge clk);
            #1;
        end
        input_valid = 1'b0;
        chk_cnt++;
        if ({x_valid, x_data, busy} !== {1'b1, 16'h400A, 1'b1})
            $display("FAIL pre_reset got=%h exp=%h", {x_valid, x_data, busy}, {1'b1, 16'h400A, 1'b1});
        else pass_cnt++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err = 1'b0;
        chk_cnt++;
        if ({x_valid, x_last_i, x_last_b, x_last_s, x_last_r, busy} !== 6'b0)
            $display("FAIL post_reset got=%b exp=000000", {x_valid, x_last_i, x_last_b, x_last_s, x_last_r, busy});
        else pass_cnt++;
        run_stream(48, 3, 1, 2, 1, 16'h5000, 1'b0, -1, 0, -1, cyc);
    endtask

`ifdef LCPLC_FRAMER_LAST_CHECK_EN
    task automatic test_last_check();
        int cyc;
        set_cfg(3, 1, 2, 1);
        run_stream(48, 3, 1, 2, 1, 16'h6000, 1'b0, -1, 0, 46, cyc);
        chk_cnt++;
        if (err_last !== 1'b1) $display("FAIL err_last_sticky got=%b exp=1", err_last);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_single();
        test_back_to_back_stall();
        test_cfg_change();
        test_mid_reset();
`ifdef LCPLC_FRAMER_LAST_CHECK_EN
        test_last_check();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
